core_data_bridge: RTL and testbench
===================================

Name: core_data_bridge

Overview:
- Sits between the ibex data port (req/gnt/rvalid) and host port 0 of the L1 variable-latency interconnect (valid/ready).
- Decodes the core address against the system map using base/mask and builds the interconnect target address.
- Enforces in-order responses with bounded outstanding transactions.
- Answers unmapped accesses locally with a bus error instead of forwarding them.

Parameters:
- DATA_WIDTH, 32, data/address width.
- MAX_OUTSTANDING, 2, maximum accepted but unanswered requests (1..4).
- NUM_DEVICES, 6, number of decoded targets.
- DEV_IDX_W, 3, width of the device index field in the target address.

Ports:
- clk_sys_in  in  1  system clock
- rst_sys_in  in  1  reset
- core_req_i  in  1  core data request
- core_gnt_o  out  1  request accepted this cycle
- core_we_i  in  1  write enable
- core_be_i  in  DATA_WIDTH/8  byte enables
- core_addr_i  in  DATA_WIDTH  byte address
- core_wdata_i  in  DATA_WIDTH  write data
- core_rvalid_o  out  1  response valid
- core_rdata_o  out  DATA_WIDTH  read data
- core_err_o  out  1  response is a decode error
- net_req_valid_o  out  1  request to interconnect
- net_req_ready_i  in  1  interconnect accepts request
- net_tgt_addr_o  out  DATA_WIDTH  encoded target address
- net_wen_o  out  1  write enable
- net_be_o  out  DATA_WIDTH/8  byte enables
- net_wdata_o  out  DATA_WIDTH  write data
- net_resp_valid_i  in  1  interconnect response valid
- net_resp_ready_o  out  1  bridge accepts response
- net_resp_data_i  in  DATA_WIDTH  response data

Interface decision: reset rst_sys_in, asynchronous, active-low; clock clk_sys_in.

Behaviour:
- Decode (combinational):
  - hit[i] = (core_addr_i & MASK[i]) == BASE[i].
  - At most one hit by construction of the map.
  - No hit means decode error.
- Target encoding:
  - net_tgt_addr_o = {core_addr_i[DATA_WIDTH-6:0], dev_idx[2:0], 2'b00}.
  - we/be/wdata pass through combinationally.
- Outstanding tracking:
  - Tag FIFO, depth MAX_OUTSTANDING, 1-bit tag: 0 = network, 1 = error.
  - Count occ in 0..MAX_OUTSTANDING.
- Grant rules:
  - Mapped access: net_req_valid_o = core_req_i & hit & (occ < MAX).
  - Mapped access: core_gnt_o = net_req_valid_o & net_req_ready_i; on grant, push tag 0.
  - Unmapped access: net_req_valid_o = 0; core_gnt_o = core_req_i & (occ < MAX); on grant, push tag 1.
  - A pop in the same cycle does not free a slot for a same-cycle grant (occ is registered).
- Response, FIFO non-empty, head tag 0:
  - net_resp_ready_o = 1.
  - On net_resp_valid_i, pop and register rdata.
  - Next cycle: core_rvalid_o = 1, core_err_o = 0.
- Response, FIFO non-empty, head tag 1:
  - net_resp_ready_o = 0.
  - Pop immediately.
  - Next cycle: core_rvalid_o = 1, core_err_o = 1, core_rdata_o = 0.
- Response, FIFO empty:
  - net_resp_ready_o = 1.
  - Any arriving response is discarded (drain of stale traffic after reset); no core_rvalid_o.
- Responses: every network request, read or write, returns exactly one response. Core responses stay in grant order.
- Latency:
  - Network access: network response cycle + 1.
  - Isolated error: grant cycle + 1.
  - Back-to-back pops: one response per cycle.
- Push and pop in the same cycle: occ unchanged, FIFO pointers both advance.
- Reset values: core_gnt_o=0, core_rvalid_o=0, core_err_o=0, core_rdata_o=0, net_req_valid_o=0, net_resp_ready_o=1 (FIFO empty), occ=0.
- Reset mid-operation discards all tags.

Optional Feature:
- Macro: CORE_DATA_BRIDGE_STATS_EN.
- Defined:
  - Adds output stat_req_cnt_o[31:0], counting granted mapped accesses.
  - Adds output stat_err_cnt_o[31:0], counting granted unmapped accesses.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package core_data_bridge_pkg:
  - bus_device_e: Ram=0, Gpio=1, Uart=2, Timer=3, Fraise=4, SimCtrl=5.
  - BASE/MASK constant arrays:
    - RAM 0x00100000/64KiB.
    - GPIO 0x80000000/4KiB.
    - UART 0x80001000/4KiB.
    - TIMER 0x80002000/4KiB.
    - FRAISE 0x80003000/4KiB.
    - SIMCTRL 0x00020000/1KiB.
  - NUM_DEVICES.
- Sub-module: core_data_bridge_tag_fifo (parameterised depth/width FIFO, full/empty, simultaneous push/pop).

Test Plan:
- Read 0x00100010, net ready=1, response 0xDEADBEEF two cycles after grant -> gnt same cycle, net_tgt_addr_o = {addr[26:0],3'd0,2'b00}, core_rvalid_o with rdata 0xDEADBEEF on the following cycle, err=0.
- Write 0x80001000, be=4'b0001 -> tgt index 2, wen=1, one core_rvalid_o after the network response.
- Read 0x40000000 (unmapped) with FIFO empty -> gnt, no net_req_valid_o, rvalid+err=1, rdata=0 one cycle later.
- Read to RAM outstanding (no response yet), then unmapped read granted -> error response held until RAM response delivered; order RAM then error.
- Three back-to-back requests with net responses withheld, MAX_OUTSTANDING=2 -> third not granted until first response popped.
- Assert reset with 2 outstanding, then inject a stale net response -> accepted by net_resp_ready_o=1, no core_rvalid_o, occ=0.

Source files
------------

// File: rtl/core_data_bridge_pkg.sv
// System address map and device enumeration shared by the core data bridge.
// Each device decodes as (addr & DEV_MASK[i]) == DEV_BASE[i].
package core_data_bridge_pkg;

  localparam int NUM_DEVICES = 6;
  localparam int DEV_IDX_W   = 3;

  typedef enum logic [DEV_IDX_W-1:0] {
    Ram     = 3'd0,
    Gpio    = 3'd1,
    Uart    = 3'd2,
    Timer   = 3'd3,
    Fraise  = 3'd4,
    SimCtrl = 3'd5
  } bus_device_e;

  // Indexed by bus_device_e; RAM 64KiB, peripherals 4KiB, SimCtrl 1KiB.
  localparam logic [31:0] DEV_BASE [NUM_DEVICES] = '{
    32'h0010_0000, 32'h8000_0000, 32'h8000_1000,
    32'h8000_2000, 32'h8000_3000, 32'h0002_0000
  };

  localparam logic [31:0] DEV_MASK [NUM_DEVICES] = '{
    32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FC00
  };

endpackage

// File: rtl/core_data_bridge_tag_fifo.sv
// Small tag FIFO recording the response source of each accepted request.
// Supports simultaneous push and pop; push when full / pop when empty are ignored.
module core_data_bridge_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_sys_in,
  input  logic             rst_sys_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_sys_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/core_data_bridge.sv
// Bridges the ibex data port onto interconnect host port 0, answering unmapped
// accesses locally with an error. Optional counters: CORE_DATA_BRIDGE_STATS_EN.
module core_data_bridge #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int NUM_DEVICES     = core_data_bridge_pkg::NUM_DEVICES,
  parameter int DEV_IDX_W       = core_data_bridge_pkg::DEV_IDX_W
) (
  input  logic                    clk_sys_in,
  input  logic                    rst_sys_in,
  input  logic                    core_req_i,
  output logic                    core_gnt_o,
  input  logic                    core_we_i,
  input  logic [DATA_WIDTH/8-1:0] core_be_i,
  input  logic [DATA_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_err_o,
  output logic                    net_req_valid_o,
  input  logic                    net_req_ready_i,
  output logic [DATA_WIDTH-1:0]   net_tgt_addr_o,
  output logic                    net_wen_o,
  output logic [DATA_WIDTH/8-1:0] net_be_o,
  output logic [DATA_WIDTH-1:0]   net_wdata_o,
  input  logic                    net_resp_valid_i,
  output logic                    net_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]   net_resp_data_i
`ifdef CORE_DATA_BRIDGE_STATS_EN
  ,
  output logic [31:0]             stat_req_cnt_o,
  output logic [31:0]             stat_err_cnt_o
`endif
);

  import core_data_bridge_pkg::*;

  logic                 hit;
  logic [DEV_IDX_W-1:0] dev_idx;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 head_tag;
  logic                 err_bypass;
  logic                 head_pop;
  logic                 resp_fire;
  logic                 resp_err;
  logic                 rvalid_q;
  logic                 err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    hit     = 1'b0;
    dev_idx = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if ((core_addr_i[31:0] & DEV_MASK[i]) == DEV_BASE[i]) begin
        hit     = 1'b1;
        dev_idx = DEV_IDX_W'(i);
      end
    end
  end

  assign net_tgt_addr_o  = {core_addr_i[DATA_WIDTH-DEV_IDX_W-3:0], dev_idx, 2'b00};
  assign net_wen_o       = core_we_i;
  assign net_be_o        = core_be_i;
  assign net_wdata_o     = core_wdata_i;

  // Slot availability uses registered occupancy, so a same-cycle pop never frees a slot.
  assign net_req_valid_o = core_req_i & hit & ~fifo_full;
  assign core_gnt_o      = hit ? (net_req_valid_o & net_req_ready_i) : (core_req_i & ~fifo_full);

  // An error granted into an empty FIFO is answered directly, giving grant+1 latency.
  assign err_bypass       = core_gnt_o & ~hit & fifo_empty;
  assign head_pop         = ~fifo_empty & (head_tag | net_resp_valid_i);
  assign resp_fire        = err_bypass | head_pop;
  assign resp_err         = err_bypass | (~fifo_empty & head_tag);
  assign net_resp_ready_o = fifo_empty | ~head_tag;

  core_data_bridge_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk_sys_in (clk_sys_in),
    .rst_sys_in (rst_sys_in),
    .push       (core_gnt_o & ~err_bypass),
    .push_data  (~hit),
    .pop        (head_pop),
    .head_data  (head_tag),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= resp_fire;
      err_q    <= resp_fire & resp_err;
      if (resp_fire) rdata_q <= resp_err ? '0 : net_resp_data_i;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_err_o    = err_q;
  assign core_rdata_o  = rdata_q;

`ifdef CORE_DATA_BRIDGE_STATS_EN
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      stat_req_cnt_o <= '0;
      stat_err_cnt_o <= '0;
    end else begin
      if (core_gnt_o && hit && (stat_req_cnt_o != 32'hFFFF_FFFF))
        stat_req_cnt_o <= stat_req_cnt_o + 32'd1;
      if (core_gnt_o && !hit && (stat_err_cnt_o != 32'hFFFF_FFFF))
        stat_err_cnt_o <= stat_err_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_data_bridge.sv
// Self-checking bench for core_data_bridge: directed scenarios then random traffic,
// checked against a queue-based response model.
module tb_core_data_bridge;

  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic          clk_sys_in;
  logic          rst_sys_in;
  logic          core_req_i;
  logic          core_gnt_o;
  logic          core_we_i;
  logic [DW/8-1:0] core_be_i;
  logic [DW-1:0] core_addr_i;
  logic [DW-1:0] core_wdata_i;
  logic          core_rvalid_o;
  logic [DW-1:0] core_rdata_o;
  logic          core_err_o;
  logic          net_req_valid_o;
  logic          net_req_ready_i;
  logic [DW-1:0] net_tgt_addr_o;
  logic          net_wen_o;
  logic [DW/8-1:0] net_be_o;
  logic [DW-1:0] net_wdata_o;
  logic          net_resp_valid_i;
  logic          net_resp_ready_o;
  logic [DW-1:0] net_resp_data_i;

  core_data_bridge #(
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_sys_in       (clk_sys_in),
    .rst_sys_in       (rst_sys_in),
    .core_req_i       (core_req_i),
    .core_gnt_o       (core_gnt_o),
    .core_we_i        (core_we_i),
    .core_be_i        (core_be_i),
    .core_addr_i      (core_addr_i),
    .core_wdata_i     (core_wdata_i),
    .core_rvalid_o    (core_rvalid_o),
    .core_rdata_o     (core_rdata_o),
    .core_err_o       (core_err_o),
    .net_req_valid_o  (net_req_valid_o),
    .net_req_ready_i  (net_req_ready_i),
    .net_tgt_addr_o   (net_tgt_addr_o),
    .net_wen_o        (net_wen_o),
    .net_be_o         (net_be_o),
    .net_wdata_o      (net_wdata_o),
    .net_resp_valid_i (net_resp_valid_i),
    .net_resp_ready_o (net_resp_ready_o),
    .net_resp_data_i  (net_resp_data_i)
  );

  initial begin
    clk_sys_in = 1'b0;
    forever #5 clk_sys_in = ~clk_sys_in;
  end

  // Address map expressed as inclusive base plus size in bytes.
  localparam logic [31:0] MAP_BASE [6] = '{32'h0010_0000, 32'h8000_0000, 32'h8000_1000,
                                           32'h8000_2000, 32'h8000_3000, 32'h0002_0000};
  localparam logic [31:0] MAP_SIZE [6] = '{32'h0001_0000, 32'h0000_1000, 32'h0000_1000,
                                           32'h0000_1000, 32'h0000_1000, 32'h0000_0400};

  int total = 0;
  int bad   = 0;

  // Model: one entry per accepted-but-unanswered request, 1 = local error.
  bit tag_q[$];
  int net_out = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  function automatic bit decode_model(input logic [31:0] a, output int idx);
    longint unsigned la = a;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (la >= longint'(MAP_BASE[i]) && la < longint'(MAP_BASE[i]) + longint'(MAP_SIZE[i])) begin
        idx = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs mid-cycle, advance the
  // model, then check the registered response just after the edge.
  task automatic applyStimulus(input bit req, input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit ready, input bit rv, input logic [31:0] rdata);
    bit mapped, slot, exp_nv, exp_gnt, exp_rdy, pop_now, pop_err, bypass;
    int idx, size0;
    logic [31:0] exp_tgt;
    core_req_i = req;  core_we_i = we;  core_be_i = be;  core_addr_i = addr;
    core_wdata_i = wdata;  net_req_ready_i = ready;
    net_resp_valid_i = rv;  net_resp_data_i = rdata;
    @(negedge clk_sys_in);
    mapped  = decode_model(addr, idx);
    size0   = tag_q.size();
    slot    = size0 < MAXO;
    exp_nv  = req && mapped && slot;
    exp_gnt = mapped ? (exp_nv && ready) : (req && slot);
    exp_rdy = (size0 == 0) || (tag_q[0] == 1'b0);
    checkOutput("gnt", {31'd0, core_gnt_o}, {31'd0, exp_gnt});
    checkOutput("net_req_valid", {31'd0, net_req_valid_o}, {31'd0, exp_nv});
    checkOutput("net_resp_ready", {31'd0, net_resp_ready_o}, {31'd0, exp_rdy});
    if (exp_nv) begin
      exp_tgt = (addr << 5) | 32'(idx << 2);
      checkOutput("tgt_addr", net_tgt_addr_o, exp_tgt);
      checkOutput("net_wen", {31'd0, net_wen_o}, {31'd0, we});
      checkOutput("net_be", {28'd0, net_be_o}, {28'd0, be});
      checkOutput("net_wdata", net_wdata_o, wdata);
    end
    pop_now = 1'b0;  pop_err = 1'b0;  bypass = 1'b0;
    if (size0 > 0) begin
      if (tag_q[0]) begin pop_now = 1'b1; pop_err = 1'b1; end
      else if (rv) pop_now = 1'b1;
      if (pop_now) void'(tag_q.pop_front());
    end else if (exp_gnt && !mapped) begin
      pop_now = 1'b1;  pop_err = 1'b1;  bypass = 1'b1;
    end
    if (rv && exp_rdy && net_out > 0) net_out--;
    if (exp_gnt && !bypass) begin
      tag_q.push_back(!mapped);
      if (mapped) net_out++;
    end
    @(posedge clk_sys_in);
    #1;
    checkOutput("rvalid", {31'd0, core_rvalid_o}, {31'd0, pop_now});
    if (pop_now) begin
      checkOutput("err", {31'd0, core_err_o}, {31'd0, pop_err});
      checkOutput("rdata", core_rdata_o, pop_err ? 32'd0 : rdata);
    end
  endtask

  task automatic idle(input bit rv, input logic [31:0] rdata);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rv, rdata);
  endtask

  task automatic reset_dut();
    rst_sys_in = 1'b0;
    core_req_i = 1'b0;  core_we_i = 1'b0;  core_be_i = '0;  core_addr_i = '0;
    core_wdata_i = '0;  net_req_ready_i = 1'b0;  net_resp_valid_i = 1'b0;
    net_resp_data_i = '0;
    tag_q.delete();
    net_out = 0;
    #12;
    checkOutput("rst_gnt", {31'd0, core_gnt_o}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, core_rvalid_o}, 32'd0);
    checkOutput("rst_err", {31'd0, core_err_o}, 32'd0);
    checkOutput("rst_rdata", core_rdata_o, 32'd0);
    checkOutput("rst_net_valid", {31'd0, net_req_valid_o}, 32'd0);
    checkOutput("rst_resp_ready", {31'd0, net_resp_ready_o}, 32'd1);
    rst_sys_in = 1'b1;
    @(posedge clk_sys_in);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 6);
    if (r == 6) begin
      case ($urandom_range(0, 2))
        0:       return 32'h4000_0000 + ($urandom & 32'h0000_FFFC);
        1:       return MAP_BASE[0] + MAP_SIZE[0];
        default: return MAP_BASE[5] + MAP_SIZE[5];
      endcase
    end
    return MAP_BASE[r] + ($urandom_range(0, MAP_SIZE[r] - 1) & 32'hFFFF_FFFC);
  endfunction

  initial begin
    bit rv_hold;
    bit rv;
    bit exp_rdy;
    logic [31:0] rv_data;
    int guard;

    reset_dut();

    // Mapped read, response two cycles after grant.
    applyStimulus(1, 0, 4'hF, 32'h0010_0010, 32'h0, 1, 0, 32'h0);
    idle(0, 32'h0);
    idle(1, 32'hDEAD_BEEF);
    idle(0, 32'h0);

    // Byte write to UART.
    applyStimulus(1, 1, 4'b0001, 32'h8000_1000, 32'hA5A5_5A5A, 1, 0, 32'h0);
    idle(1, 32'h1234_5678);
    idle(0, 32'h0);

    // Unmapped read into an empty FIFO.
    applyStimulus(1, 0, 4'hF, 32'h4000_0000, 32'h0, 1, 0, 32'h0);
    idle(0, 32'h0);

    // Error queued behind an outstanding RAM read.
    applyStimulus(1, 0, 4'hF, 32'h0010_0100, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h4000_0004, 32'h0, 1, 0, 32'h0);
    idle(0, 32'h0);
    idle(1, 32'hCAFE_F00D);
    idle(0, 32'h0);
    idle(0, 32'h0);

    // Outstanding limit: third request waits past the same-cycle pop.
    applyStimulus(1, 0, 4'hF, 32'h0010_0200, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h0010_0204, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h0010_0208, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h0010_0208, 32'h0, 1, 1, 32'h1111_1111);
    applyStimulus(1, 0, 4'hF, 32'h0010_0208, 32'h0, 1, 0, 32'h0);
    idle(1, 32'h2222_2222);
    idle(1, 32'h3333_3333);
    idle(0, 32'h0);

    // Reset with two outstanding, then a stale response is drained silently.
    applyStimulus(1, 0, 4'hF, 32'h0002_0000, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h0002_03FC, 32'h0, 1, 0, 32'h0);
    reset_dut();
    idle(1, 32'hBAD0_BAD0);
    applyStimulus(1, 0, 4'hF, 32'h8000_2000, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 4'hF, 32'h8000_3FFC, 32'h0, 0, 0, 32'h0);
    idle(0, 32'h0);

    // Random traffic with an in-order network responder.
    rv_hold = 1'b0;
    rv_data = '0;
    for (int c = 0; c < 400; c++) begin
      exp_rdy = (tag_q.size() == 0) || (tag_q[0] == 1'b0);
      if (rv_hold) rv = 1'b1;
      else if (net_out > 0 && $urandom_range(0, 2) != 0) begin
        rv = 1'b1;  rv_data = $urandom;
      end else if (net_out == 0 && tag_q.size() == 0 && $urandom_range(0, 19) == 0) begin
        rv = 1'b1;  rv_data = $urandom;
      end else rv = 1'b0;
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
                    rand_addr(), $urandom, $urandom_range(0, 3) != 0, rv, rv_data);
      rv_hold = rv && !exp_rdy;
    end

    // Drain everything still outstanding, bounded.
    guard = 0;
    while (tag_q.size() > 0 && guard < 50) begin
      rv_data = $urandom;
      idle(net_out > 0, rv_data);
      guard++;
    end
    if (tag_q.size() != 0) checkOutput("drain_timeout", tag_q.size(), 32'd0);
    idle(0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
